// File: rtl/tt_um_seq_divider.sv
// Sequential 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_DBZ_DETECT_EN: short-circuits a zero divisor to DONE with dbz flagged.
module tt_um_seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] n_q, n_d;
    logic [3:0] d_q, d_d;
    logic [4:0] p_q, p_d;
    logic [7:0] q_q, q_d;
    logic [2:0] cnt_q, cnt_d;
    logic       dbz_q, dbz_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       start_s;
    logic       sel_s;
    logic [3:0] div_s;
    logic [4:0] trial_s;
    logic       fits_s;
    logic       dbz_hit_s;
    logic       unused_s;

    assign start_s = uio_in[4];
    assign sel_s   = uio_in[5];
    assign div_s   = uio_in[3:0];

    // n_q is shifted left each step, so its MSB is always the next dividend bit.
    assign trial_s = {p_q[3:0], n_q[7]};
    assign fits_s  = (trial_s >= {1'b0, d_q});

`ifdef DIV_DBZ_DETECT_EN
    assign dbz_hit_s = (d_q == 4'd0);
`else
    assign dbz_hit_s = 1'b0;
`endif

    assign unused_s = &{1'b0, ena, uio_in[7:6], p_q[4]};

    // Next-state and datapath update for the divider FSM.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        p_d     = p_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_s) begin
                    n_d     = ui_in;
                    d_d     = div_s;
                    p_d     = 5'd0;
                    q_d     = 8'd0;
                    cnt_d   = 3'd0;
                    dbz_d   = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (dbz_hit_s) begin
                    q_d     = 8'hFF;
                    p_d     = 5'h0F;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    p_d   = fits_s ? (trial_s - {1'b0, d_q}) : trial_s;
                    q_d   = {q_q[6:0], fits_s};
                    n_d   = {n_q[6:0], 1'b0};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, operand and result registers; busy/done are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= 8'd0;
            d_q     <= 4'd0;
            p_q     <= 5'd0;
            q_q     <= 8'd0;
            cnt_q   <= 3'd0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign uo_out  = sel_s ? {dbz_q, 3'b000, p_q[3:0]} : q_q;
    assign uio_out = {done_q, busy_q, 6'b00_0000};
    assign uio_oe  = 8'b1100_0000;

endmodule
